// File: rtl/shift_cmd_queue.sv
// Issue stage for the 8-bit barrel shifter: buffers shift commands in a small FIFO,
// presents the head to the shifter and registers its result behind a valid/ready port.
module shift_cmd_queue #(
    parameter int DEPTH = 4,
    parameter int DW    = 8,
    parameter int SW    = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DW-1:0]            in_data,
    input  logic [SW-1:0]            in_shift,
    output logic [DW-1:0]            sh_datain,
    output logic [SW-1:0]            sh_shift,
    input  logic [DW-1:0]            sh_dataout,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DW-1:0]            out_data,
    output logic [SW-1:0]            out_shift,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW-1:0] PTR_ONE  = 1;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [SW-1:0] shift;
    } cmd_t;

    cmd_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_nxt;
    logic          push;
    logic          load;

    // Full is decided from registered occupancy only, so a same-edge pop never frees a slot.
    assign in_ready  = (count != CNT_FULL);
    assign push      = in_valid & in_ready & ~clr;
    assign load      = (count != '0) & (~out_valid | out_ready) & ~clr;

    assign sh_datain = mem[rd_ptr].data;
    assign sh_shift  = mem[rd_ptr].shift;

    // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        count_nxt = count;
        if (push && !load) begin
            count_nxt = count + CNT_ONE;
        end else if (load && !push) begin
            count_nxt = count - CNT_ONE;
        end
    end

    // NOTE: the storage array is reset explicitly so the head outputs read 0 after reset; clr leaves it untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= '{data: in_data, shift: in_shift};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_shift <= '0;
        end else if (clr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
        end else begin
            count <= count_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (load) begin
                rd_ptr    <= rd_ptr + PTR_ONE;
                out_data  <= sh_dataout;
                out_shift <= sh_shift;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                // Result consumed with nothing queued behind it; data/shift keep their values.
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_shift_cmd_queue.sv
// Scoreboard bench for shift_cmd_queue: a queue-level reference model predicts results,
// a negedge monitor compares whatever the DUT presents.
module tb_shift_cmd_queue;

    localparam int DEPTH = 4;

    typedef struct {
        logic [7:0] data;
        logic [2:0] shift;
    } cmd_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic [2:0] in_shift = '0;
    logic [7:0] sh_datain;
    logic [2:0] sh_shift;
    logic [7:0] sh_dataout;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic [2:0] out_shift;
    logic [2:0] count;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: queued commands, output register, undelivered results.
    cmd_t       m_fifo[$];
    cmd_t       sb[$];
    bit         m_ov = 1'b0;
    logic [7:0] m_out_data = '0;
    logic [2:0] m_out_shift = '0;
    int         n_acc = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] rotl(input logic [7:0] d, input logic [2:0] s);
        logic [15:0] t;
        t = {d, d} << s;
        return t[15:8];
    endfunction

    assign sh_dataout = rotl(sh_datain, sh_shift);

    shift_cmd_queue #(.DEPTH(DEPTH), .DW(8), .SW(3)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_shift(in_shift),
        .sh_datain(sh_datain), .sh_shift(sh_shift), .sh_dataout(sh_dataout),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_shift(out_shift),
        .count(count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: advances on each edge from the inputs the bench drove for that cycle.
    always @(posedge clk or negedge rst_n) begin
        cmd_t c;
        bit   ready;
        bit   do_load;
        if (!rst_n) begin
            m_fifo.delete();
            sb.delete();
            m_ov        = 1'b0;
            m_out_data  = '0;
            m_out_shift = '0;
        end else if (clr) begin
            m_fifo.delete();
            sb.delete();
            m_ov = 1'b0;
        end else begin
            ready   = (m_fifo.size() != DEPTH);
            do_load = (m_fifo.size() != 0) && (!m_ov || out_ready);
            if (do_load) begin
                c           = m_fifo.pop_front();
                m_ov        = 1'b1;
                m_out_data  = rotl(c.data, c.shift);
                m_out_shift = c.shift;
            end else if (m_ov && out_ready) begin
                m_ov = 1'b0;
            end
            if (in_valid && ready) begin
                c.data  = in_data;
                c.shift = in_shift;
                m_fifo.push_back(c);
                c.data = rotl(in_data, in_shift);
                sb.push_back(c);
                n_acc++;
            end
        end
    end

    // Monitor: compares status against the model and pops the scoreboard on each delivered result.
    always @(negedge clk) begin
        cmd_t e;
        check("count", count, m_fifo.size());
        check("in_ready", in_ready, (m_fifo.size() != DEPTH));
        check("out_valid", out_valid, m_ov);
        if (m_ov) begin
            check("out_data_hold", out_data, m_out_data);
            check("out_shift_hold", out_shift, m_out_shift);
        end
        if (m_fifo.size() != 0) begin
            check("sh_datain", sh_datain, m_fifo[0].data);
            check("sh_shift", sh_shift, m_fifo[0].shift);
        end
        if (out_valid && out_ready && rst_n) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_result", 1, 0);
            end else begin
                e = sb.pop_front();
                check("sb_out_data", out_data, e.data);
                check("sb_out_shift", out_shift, e.shift);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int k;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        k = 0;
        while ((m_fifo.size() != 0 || m_ov) && k < 40) begin
            step();
            k++;
        end
        check("drain_done", (k < 40), 1);
        check("sb_empty", sb.size(), 0);
    endtask

    task automatic push_n(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            in_shift = 3'($urandom);
            step();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        int start;

        #12 rst_n = 1'b1;
        step();
        check("rst_count", count, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_shift", out_shift, 0);
        check("rst_sh_datain", sh_datain, 0);
        check("rst_sh_shift", sh_shift, 0);
        check("rst_in_ready", in_ready, 1);

        // Single command: visible one edge after acceptance.
        in_valid = 1'b1; in_data = 8'hBB; in_shift = 3'd1;
        step();
        in_valid = 1'b0;
        check("single_n_out_valid", out_valid, 0);
        check("single_n_count", count, 1);
        step();
        check("single_n1_out_valid", out_valid, 1);
        check("single_n1_out_data", out_data, 8'h77);
        check("single_n1_out_shift", out_shift, 1);
        check("single_n1_count", count, 0);
        drain();

        // Fill with the output stalled, then overfill.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 8'hBB; in_shift = 3'(i);
            step();
        end
        check("fill_count3", count, 3);
        in_shift = 3'd4;
        step();
        check("fill_count4", count, 4);
        check("fill_in_ready0", in_ready, 0);
        in_shift = 3'd5;
        step();
        step();
        check("overfill_count4", count, 4);
        in_valid = 1'b0;

        // Back-to-back drain, one result per cycle.
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("drain_b2b_valid", out_valid, 1);
            check("drain_b2b_shift", out_shift, i);
            check("drain_b2b_data", out_data, rotl(8'hBB, 3'(i)));
            step();
        end
        check("drain_b2b_idle", out_valid, 0);
        drain();

        // Random commands with random backpressure.
        start = n_acc;
        for (int cyc = 0; cyc < 3000 && (n_acc - start) < 64; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            in_shift  = 3'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            step();
        end
        check("random_64_accepted", ((n_acc - start) >= 64), 1);
        drain();

        // Simultaneous push and pop at count 3; pointers wrap more than twice.
        out_ready = 1'b0;
        push_n(4);
        check("pp_setup_count", count, 3);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data  = 8'($urandom);
            in_shift = 3'($urandom);
            step();
            check("pp_count3", count, 3);
        end
        drain();

        // Flush with count 2 and a pending result; clr overrides a concurrent push.
        out_ready = 1'b0;
        push_n(3);
        check("clr_setup_count", count, 2);
        check("clr_setup_valid", out_valid, 1);
        clr = 1'b1; in_valid = 1'b1;
        step();
        clr = 1'b0; in_valid = 1'b0;
        check("clr_count", count, 0);
        check("clr_out_valid", out_valid, 0);
        check("clr_in_ready", in_ready, 1);
        drain();

        // Asynchronous reset in the middle of traffic.
        for (int i = 0; i < 6; i++) begin
            in_valid  = 1'b1;
            in_data   = 8'($urandom);
            in_shift  = 3'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            step();
        end
        in_valid = 1'b1; in_data = 8'hFF; in_shift = 3'd7;
        out_ready = 1'b0;
        push_n(2);
        #2 rst_n = 1'b0;
        #1;
        check("arst_count", count, 0);
        check("arst_out_valid", out_valid, 0);
        check("arst_out_data", out_data, 0);
        check("arst_out_shift", out_shift, 0);
        check("arst_sh_datain", sh_datain, 0);
        check("arst_sh_shift", sh_shift, 0);
        in_valid = 1'b0;
        @(posedge clk);
        #4 rst_n = 1'b1;
        step();
        check("arst_in_ready", in_ready, 1);
        in_valid = 1'b1; in_data = 8'h81; in_shift = 3'd3;
        step();
        in_valid = 1'b0;
        step();
        check("post_rst_data", out_data, 8'h0C);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
